// File: rtl/hsaf_pkg.sv
// +----------------------------------------------------------------------------+
// | hsaf_pkg: shared state encodings and default thresholds for the MSE monitor |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package hsaf_pkg;

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_train     = 2'd1;
  localparam logic [1:0] c_st_converged = 2'd2;
  localparam logic [1:0] c_st_diverged  = 2'd3;

  localparam int c_def_conv_th = 8;
  localparam int c_def_rel_th  = 32;
  localparam int c_def_div_th  = 4096;
  localparam int c_def_hold    = 4;

endpackage

`default_nettype wire

// File: rtl/hsaf_mse_monitor_if.sv
// +----------------------------------------------------------------------------+
// | hsaf_mse_monitor_if: error-sample stream in, MSE/convergence status out.    |
// | Optional HSAF_MSE_PEAK_EN adds peak_abs_err. Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface hsaf_mse_monitor_if #(
  parameter int WIDTH = 16
);
  logic             sample_en;
  logic [WIDTH-1:0] error_in;
  logic [WIDTH-1:0] mse_out;
  logic             mse_valid;
  logic [1:0]       state_out;
  logic             converged;
  logic             diverged;
  logic [15:0]      win_count;
`ifdef HSAF_MSE_PEAK_EN
  logic [WIDTH-1:0] peak_abs_err;
`endif

`ifdef HSAF_MSE_PEAK_EN
  modport master (output sample_en, error_in,
                  input  mse_out, mse_valid, state_out, converged, diverged, win_count, peak_abs_err);
  modport slave  (input  sample_en, error_in,
                  output mse_out, mse_valid, state_out, converged, diverged, win_count, peak_abs_err);
`else
  modport master (output sample_en, error_in,
                  input  mse_out, mse_valid, state_out, converged, diverged, win_count);
  modport slave  (input  sample_en, error_in,
                  output mse_out, mse_valid, state_out, converged, diverged, win_count);
`endif
endinterface

`default_nettype wire

// File: rtl/hsaf_err_square.sv
// +----------------------------------------------------------------------------+
// | hsaf_err_square: two-stage pipeline, S1 captures the sample, S2 holds the   |
// | rounded, unsigned-saturated square in Q.QP. Rev 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module hsaf_err_square #(
  parameter int WIDTH = 16,
  parameter int QP    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_err,
  output logic             sq_vld,
  output logic [WIDTH-1:0] sq
);

  localparam logic [2*WIDTH-1:0] c_half = {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP - 1);

  logic                      r_s1_vld;
  logic signed [WIDTH-1:0]   r_s1_err;
  logic                      r_s2_vld;
  logic [WIDTH-1:0]          r_s2_sq;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0]        w_scaled;
  logic [WIDTH-1:0]          w_sat;

  assign w_prod   = r_s1_err * r_s1_err;
  assign w_scaled = ($unsigned(w_prod) + c_half) >> QP;
  assign w_sat    = (|w_scaled[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : w_scaled[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= '0;
      r_s2_vld <= 1'b0;
      r_s2_sq  <= '0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= '0;
      r_s2_vld <= 1'b0;
      r_s2_sq  <= '0;
    end else begin
      r_s1_vld <= in_vld;
      r_s1_err <= in_err;
      r_s2_vld <= r_s1_vld;
      r_s2_sq  <= w_sat;
    end
  end

  assign sq_vld = r_s2_vld;
  assign sq     = r_s2_sq;

endmodule

`default_nettype wire

// File: rtl/hsaf_mse_monitor.sv
// +----------------------------------------------------------------------------+
// | hsaf_mse_monitor: block MSE over 2^WIN_LOG2 error samples plus convergence  |
// | FSM. Define HSAF_MSE_PEAK_EN to add peak_abs_err. Rev 1.0                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module hsaf_mse_monitor
  import hsaf_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               QP       = 12,
  parameter int               WIN_LOG2 = 6,
  parameter logic [WIDTH-1:0] CONV_TH  = WIDTH'(c_def_conv_th),
  parameter logic [WIDTH-1:0] REL_TH   = WIDTH'(c_def_rel_th),
  parameter logic [WIDTH-1:0] DIV_TH   = WIDTH'(c_def_div_th),
  parameter int               HOLD     = c_def_hold
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  hsaf_mse_monitor_if.slave bus
);

  localparam int c_gw = $clog2(HOLD + 1);

  logic                      w_flush;
  logic                      w_sq_vld;
  logic [WIDTH-1:0]          w_sq;
  logic [WIDTH+WIN_LOG2-1:0] r_acc;
  logic [WIDTH+WIN_LOG2-1:0] w_sum;
  logic [WIN_LOG2-1:0]       r_cnt;
  logic                      w_win_done;
  logic [WIDTH-1:0]          w_mse_new;
  logic [WIDTH-1:0]          r_mse;
  logic                      r_mse_valid;
  logic [15:0]               r_win_count;
  logic [1:0]                r_state;
  logic [1:0]                w_state_nx;
  logic [c_gw-1:0]           r_good;
  logic [c_gw-1:0]           w_good_nx;
  logic [c_gw-1:0]           w_good_inc;
  logic [1:0]                w_state_out;
  logic                      w_converged;
  logic                      w_diverged;

  assign w_flush = !enable || clear;

  hsaf_err_square #(
    .WIDTH (WIDTH),
    .QP    (QP)
  ) u_square (
    .clk    (clk),
    .reset  (reset),
    .flush  (w_flush),
    .in_vld (bus.sample_en),
    .in_err (bus.error_in),
    .sq_vld (w_sq_vld),
    .sq     (w_sq)
  );

  assign w_sum      = r_acc + {{WIN_LOG2{1'b0}}, w_sq};
  assign w_mse_new  = w_sum[WIDTH+WIN_LOG2-1:WIN_LOG2];
  assign w_win_done = w_sq_vld && (r_cnt == {WIN_LOG2{1'b1}});

  // mse_out and the peak are deliberately not cleared by enable/clear: they hold the last window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mse       <= '0;
      r_mse_valid <= 1'b0;
      r_win_count <= '0;
    end else if (!enable) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mse_valid <= 1'b0;
      r_win_count <= '0;
    end else if (clear) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mse_valid <= 1'b0;
    end else if (w_win_done) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mse       <= w_mse_new;
      r_mse_valid <= 1'b1;
      if (r_win_count != 16'hFFFF) r_win_count <= r_win_count + 16'd1;
    end else if (w_sq_vld) begin
      r_acc       <= w_sum;
      r_cnt       <= r_cnt + WIN_LOG2'(1);
      r_mse_valid <= 1'b0;
    end else begin
      r_mse_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_good  <= w_good_nx;
    end
  end

  assign w_good_inc = r_good + c_gw'(1);

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    if (!enable) begin
      w_state_nx = c_st_idle;
      w_good_nx  = '0;
    end else if (clear) begin
      w_state_nx = c_st_train;
      w_good_nx  = '0;
    end else begin
      case (r_state)
        c_st_idle: w_state_nx = c_st_train;
        c_st_train: begin
          if (w_win_done) begin
            if (w_mse_new >= DIV_TH) begin
              w_state_nx = c_st_diverged;
              w_good_nx  = '0;
            end else if (w_mse_new <= CONV_TH) begin
              if (w_good_inc == c_gw'(HOLD)) begin
                w_state_nx = c_st_converged;
                w_good_nx  = '0;
              end else begin
                w_good_nx = w_good_inc;
              end
            end else begin
              w_good_nx = '0;
            end
          end
        end
        c_st_converged: begin
          if (w_win_done) begin
            if (w_mse_new >= DIV_TH) begin
              w_state_nx = c_st_diverged;
            end else if (w_mse_new > REL_TH) begin
              w_state_nx = c_st_train;
              w_good_nx  = '0;
            end
          end
        end
        default: w_state_nx = c_st_diverged;
      endcase
    end
  end

  always_comb begin
    w_state_out = r_state;
    w_converged = (r_state == c_st_converged);
    w_diverged  = (r_state == c_st_diverged);
  end

  assign bus.mse_out   = r_mse;
  assign bus.mse_valid = r_mse_valid;
  assign bus.state_out = w_state_out;
  assign bus.converged = w_converged;
  assign bus.diverged  = w_diverged;
  assign bus.win_count = r_win_count;

`ifdef HSAF_MSE_PEAK_EN
  localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] r_abs1;
  logic [WIDTH-1:0] r_abs2;
  logic [WIDTH-1:0] r_peak_run;
  logic [WIDTH-1:0] r_peak;
  logic [WIDTH-1:0] w_peak_now;

  always_comb begin
    w_abs = bus.error_in;
    if (bus.error_in == c_min_neg)   w_abs = c_max_pos;
    else if (bus.error_in[WIDTH-1]) w_abs = {WIDTH{1'b0}} - bus.error_in;
  end

  assign w_peak_now = (r_abs2 > r_peak_run) ? r_abs2 : r_peak_run;

  // abs pipeline mirrors the squaring stages so the peak closes with the same window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_abs1     <= '0;
      r_abs2     <= '0;
      r_peak_run <= '0;
      r_peak     <= '0;
    end else if (w_flush) begin
      r_abs1     <= '0;
      r_abs2     <= '0;
      r_peak_run <= '0;
    end else begin
      r_abs1 <= bus.sample_en ? w_abs : '0;
      r_abs2 <= r_abs1;
      if (w_win_done) begin
        r_peak     <= w_peak_now;
        r_peak_run <= '0;
      end else if (w_sq_vld) begin
        r_peak_run <= w_peak_now;
      end
    end
  end

  assign bus.peak_abs_err = r_peak;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hsaf_mse_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_hsaf_mse_monitor: directed self-checking bench for hsaf_mse_monitor      |
// | (WIDTH=16, QP=12, WIN_LOG2=4, HOLD=2). Rev 1.0                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hsaf_mse_monitor;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;
  logic clear  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  hsaf_mse_monitor_if #(.WIDTH(16)) bus ();

  hsaf_mse_monitor #(
    .WIDTH    (16),
    .QP       (12),
    .WIN_LOG2 (4),
    .HOLD     (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0; clear = 1'b0; bus.sample_en = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  // ticks until mse_valid is seen (bounded); returns the number of ticks taken
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.mse_valid !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    bus.sample_en = 1'b0; bus.error_in = 16'h0000;
    tick(); tick();
    n_tests++; if (bus.state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state_out); end
    n_tests++; if (bus.mse_out !== 16'h0000) begin n_fail++; $display("FAIL reset_mse got %0h exp 0", bus.mse_out); end
    n_tests++; if ({bus.mse_valid, bus.converged, bus.diverged} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.mse_valid, bus.converged, bus.diverged}); end
    n_tests++; if (bus.win_count !== 16'd0) begin n_fail++; $display("FAIL reset_wincnt got %0d exp 0", bus.win_count); end
    reset = 1'b1; enable = 1'b1;
    tick();
    n_tests++; if (bus.state_out !== 2'd1) begin n_fail++; $display("FAIL reset_to_train got %0d exp 1", bus.state_out); end
  endtask

  task automatic test_mse_basic();
    bit early = 1'b0;
    bus.sample_en = 1'b1; bus.error_in = 16'h0100;
    repeat (17) begin
      tick();
      if (bus.mse_valid === 1'b1) early = 1'b1;
    end
    n_tests++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got 1 exp 0"); end
    tick();
    n_tests++; if (bus.mse_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency valid got %b exp 1", bus.mse_valid); end
    n_tests++; if (bus.mse_out !== 16'h0010) begin n_fail++; $display("FAIL basic_mse got %0h exp 10", bus.mse_out); end
    n_tests++; if (bus.state_out !== 2'd1) begin n_fail++; $display("FAIL basic_state got %0d exp 1", bus.state_out); end
    n_tests++; if (bus.win_count !== 16'd1) begin n_fail++; $display("FAIL basic_wincnt got %0d exp 1", bus.win_count); end
    tick();
    n_tests++; if (bus.mse_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %b exp 0", bus.mse_valid); end
    n_tests++; if (bus.mse_out !== 16'h0010) begin n_fail++; $display("FAIL basic_mse_hold got %0h exp 10", bus.mse_out); end
  endtask

  task automatic test_async_reset();
    #3 reset = 1'b0;
    #1;
    n_tests++; if (bus.mse_out !== 16'h0000) begin n_fail++; $display("FAIL areset_mse got %0h exp 0", bus.mse_out); end
    n_tests++; if (bus.win_count !== 16'd0) begin n_fail++; $display("FAIL areset_wincnt got %0d exp 0", bus.win_count); end
    n_tests++; if (bus.state_out !== 2'd0) begin n_fail++; $display("FAIL areset_state got %0d exp 0", bus.state_out); end
    tick();
    reset = 1'b1;
    restart();
  endtask

  task automatic test_converge();
    int n;
    restart();
    bus.sample_en = 1'b1; bus.error_in = 16'h0040;
    wait_valid(n);
    n_tests++; if (n !== 18) begin n_fail++; $display("FAIL conv_latency got %0d exp 18", n); end
    n_tests++; if (bus.mse_out !== 16'd1 || bus.state_out !== 2'd1) begin n_fail++; $display("FAIL conv_w1 mse %0d st %0d exp 1 1", bus.mse_out, bus.state_out); end
    wait_valid(n);
    n_tests++; if (bus.converged !== 1'b1 || bus.state_out !== 2'd2) begin n_fail++; $display("FAIL conv_w2 conv %b st %0d exp 1 2", bus.converged, bus.state_out); end
    bus.error_in = 16'h0100;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd14 || bus.state_out !== 2'd2) begin n_fail++; $display("FAIL conv_band_w3 mse %0d st %0d exp 14 2", bus.mse_out, bus.state_out); end
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd16 || bus.converged !== 1'b1) begin n_fail++; $display("FAIL conv_band_w4 mse %0d conv %b exp 16 1", bus.mse_out, bus.converged); end
    bus.error_in = 16'h0200;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd58 || bus.state_out !== 2'd1 || bus.converged !== 1'b0) begin n_fail++; $display("FAIL conv_release mse %0d st %0d exp 58 1", bus.mse_out, bus.state_out); end
  endtask

  task automatic test_diverge();
    int n;
    restart();
    bus.sample_en = 1'b1; bus.error_in = 16'h7FFF;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'hFFFF || bus.state_out !== 2'd3 || bus.diverged !== 1'b1) begin n_fail++; $display("FAIL div_sat mse %0h st %0d exp ffff 3", bus.mse_out, bus.state_out); end
    bus.error_in = 16'h0040;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd8192 || bus.state_out !== 2'd3) begin n_fail++; $display("FAIL div_mixed mse %0d st %0d exp 8192 3", bus.mse_out, bus.state_out); end
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd1 || bus.state_out !== 2'd3) begin n_fail++; $display("FAIL div_sticky mse %0d st %0d exp 1 3", bus.mse_out, bus.state_out); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++; if (bus.state_out !== 2'd1 || bus.diverged !== 1'b0) begin n_fail++; $display("FAIL div_clear st %0d exp 1", bus.state_out); end
    wait_valid(n);
    n_tests++; if (n !== 18 || bus.mse_out !== 16'd1) begin n_fail++; $display("FAIL div_restart n %0d mse %0d exp 18 1", n, bus.mse_out); end
  endtask

  task automatic test_boundaries();
    int n;
    restart();
    bus.sample_en = 1'b1; bus.error_in = 16'h00B5;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd8 || bus.state_out !== 2'd1) begin n_fail++; $display("FAIL bnd_conv_w1 mse %0d st %0d exp 8 1", bus.mse_out, bus.state_out); end
    wait_valid(n);
    n_tests++; if (bus.state_out !== 2'd2) begin n_fail++; $display("FAIL bnd_conv_eq st %0d exp 2", bus.state_out); end
    bus.error_in = 16'h016A;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd29 || bus.state_out !== 2'd2) begin n_fail++; $display("FAIL bnd_rel_w3 mse %0d st %0d exp 29 2", bus.mse_out, bus.state_out); end
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd32 || bus.state_out !== 2'd2) begin n_fail++; $display("FAIL bnd_rel_eq mse %0d st %0d exp 32 2", bus.mse_out, bus.state_out); end
    restart();
    bus.sample_en = 1'b1; bus.error_in = 16'h1000;
    wait_valid(n);
    n_tests++; if (bus.mse_out !== 16'd4096 || bus.state_out !== 2'd3) begin n_fail++; $display("FAIL bnd_div_eq mse %0d st %0d exp 4096 3", bus.mse_out, bus.state_out); end
  endtask

  task automatic test_gaps();
    int nvalid = 0;
    int t1 = 0;
    int t2 = 0;
    restart();
    bus.error_in = 16'h0100;
    for (int t = 1; t <= 130; t++) begin
      bus.sample_en = (t % 2 == 1);
      clear = (t == 97);
      tick();
      if (bus.mse_valid === 1'b1) begin
        nvalid++;
        if (nvalid == 1) t1 = t;
        if (nvalid == 2) t2 = t;
      end
    end
    clear = 1'b0;
    n_tests++; if (t1 !== 33 || t2 !== 65) begin n_fail++; $display("FAIL gap_timing got %0d,%0d exp 33,65", t1, t2); end
    n_tests++; if (nvalid !== 2) begin n_fail++; $display("FAIL gap_clear_suppress got %0d pulses exp 2", nvalid); end
    n_tests++; if (bus.mse_out !== 16'd16 || bus.win_count !== 16'd2) begin n_fail++; $display("FAIL gap_mse mse %0d wc %0d exp 16 2", bus.mse_out, bus.win_count); end
  endtask

  task automatic test_enable_low();
    int n;
    restart();
    bus.sample_en = 1'b1; bus.error_in = 16'h0100;
    wait_valid(n);
    repeat (8) tick();
    enable = 1'b0;
    tick();
    n_tests++; if (bus.state_out !== 2'd0 || bus.win_count !== 16'd0) begin n_fail++; $display("FAIL en_low st %0d wc %0d exp 0 0", bus.state_out, bus.win_count); end
    n_tests++; if (bus.mse_out !== 16'd16) begin n_fail++; $display("FAIL en_low_hold mse %0d exp 16", bus.mse_out); end
    enable = 1'b1; bus.sample_en = 1'b0;
    tick();
    n_tests++; if (bus.state_out !== 2'd1) begin n_fail++; $display("FAIL en_high st %0d exp 1", bus.state_out); end
    bus.sample_en = 1'b1; bus.error_in = 16'h0040;
    wait_valid(n);
    n_tests++; if (n !== 18 || bus.mse_out !== 16'd1) begin n_fail++; $display("FAIL en_partial_drop n %0d mse %0d exp 18 1", n, bus.mse_out); end
  endtask

`ifdef HSAF_MSE_PEAK_EN
  task automatic test_peak();
    int n;
    logic [15:0] seq [16];
    for (int i = 0; i < 16; i++) seq[i] = 16'h0100;
    seq[7] = 16'h8000;
    seq[8] = 16'hF000;
    restart();
    for (int i = 0; i < 16; i++) begin
      bus.sample_en = 1'b1; bus.error_in = seq[i];
      tick();
    end
    bus.sample_en = 1'b0;
    wait_valid(n);
    n_tests++; if (bus.peak_abs_err !== 16'h7FFF) begin n_fail++; $display("FAIL peak_sat got %0h exp 7fff", bus.peak_abs_err); end
    bus.sample_en = 1'b1; bus.error_in = 16'hF000;
    wait_valid(n);
    n_tests++; if (bus.peak_abs_err !== 16'h1000) begin n_fail++; $display("FAIL peak_new_window got %0h exp 1000", bus.peak_abs_err); end
  endtask
`endif

  initial begin
    bus.sample_en = 1'b0;
    bus.error_in  = 16'h0000;
    test_reset();
    test_mse_basic();
    test_async_reset();
    test_converge();
    test_diverge();
    test_boundaries();
    test_gaps();
    test_enable_low();
`ifdef HSAF_MSE_PEAK_EN
    test_peak();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
